conv3x3_fold_seq: RTL

Folded 3x3 dual-kernel convolution engine: one signed multiplier and one accumulator per kernel are time-shared over the nine taps of a window. It generalises the fixed-Sobel, externally-counted filter. Pixel width, coefficient width, accumulator width and output width are parameters. Both kernels are loaded per window. An internal tap counter and FSM sequence the taps, and valid/ready handshakes on input and output replace the external `count` bus. It sits between the line-buffer/window generator and the edge-map writer of the image pipeline.

---
 rtl/conv3x3_fold_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/conv3x3_fold_seq.sv
// ============================================================================
// conv3x3_fold_seq : folded 3x3 dual-kernel convolution, one MAC per kernel
// Revision 1.0
// ============================================================================
`default_nettype none

module conv3x3_fold_seq #(
  parameter int PX_W   = 8,
  parameter int COEF_W = 3,
  parameter int ACC_W  = 16,
  parameter int OUT_W  = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [9*PX_W-1:0]     px_win,
  input  logic [9*COEF_W-1:0]   coef_x,
  input  logic [9*COEF_W-1:0]   coef_y,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  busy
);

  localparam int PROD_W = PX_W + COEF_W + 1;
  localparam int CMB_W  = ACC_W + 2;

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_MAC  = 2'd1;
  localparam logic [1:0] c_S_FIN  = 2'd2;
  localparam logic [1:0] c_S_OUT  = 2'd3;

  generate
    if (ACC_W < PX_W + COEF_W + 5) begin : g_acc_w_check
      $error("conv3x3_fold_seq: ACC_W must be >= PX_W+COEF_W+5");
    end
  endgenerate

  logic [1:0]              r_state;
  logic [3:0]              r_tap;
  logic [9*PX_W-1:0]       r_px;
  logic [9*COEF_W-1:0]     r_cx;
  logic [9*COEF_W-1:0]     r_cy;
  logic [1:0]              r_mode;
  logic signed [ACC_W-1:0] r_acc_x;
  logic signed [ACC_W-1:0] r_acc_y;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [OUT_W-1:0]        r_out_data;

  logic [PX_W-1:0]          w_px_k;
  logic [COEF_W-1:0]        w_cx_k;
  logic [COEF_W-1:0]        w_cy_k;
  logic signed [PROD_W-1:0] w_px_s;
  logic signed [PROD_W-1:0] w_cx_s;
  logic signed [PROD_W-1:0] w_cy_s;
  logic signed [PROD_W-1:0] w_prod_x;
  logic signed [PROD_W-1:0] w_prod_y;
  logic signed [ACC_W-1:0]  w_add_x;
  logic signed [ACC_W-1:0]  w_add_y;

  assign w_px_k   = r_px[r_tap*PX_W +: PX_W];
  assign w_cx_k   = r_cx[r_tap*COEF_W +: COEF_W];
  assign w_cy_k   = r_cy[r_tap*COEF_W +: COEF_W];
  // Pixel is zero-extended so the unsigned value survives the signed multiply.
  assign w_px_s   = PROD_W'({1'b0, w_px_k});
  assign w_cx_s   = PROD_W'($signed(w_cx_k));
  assign w_cy_s   = PROD_W'($signed(w_cy_k));
  assign w_prod_x = w_cx_s * w_px_s;
  assign w_prod_y = w_cy_s * w_px_s;
  assign w_add_x  = ACC_W'(w_prod_x);
  assign w_add_y  = ACC_W'(w_prod_y);

  logic signed [ACC_W:0] w_ext_x;
  logic signed [ACC_W:0] w_ext_y;
  logic [ACC_W:0]        w_abs_x;
  logic [ACC_W:0]        w_abs_y;
  logic [CMB_W-1:0]      w_comb;
  logic [OUT_W-1:0]      w_sat;

  // One extra bit so the most-negative accumulator has an exact magnitude.
  assign w_ext_x = (ACC_W+1)'(r_acc_x);
  assign w_ext_y = (ACC_W+1)'(r_acc_y);
  assign w_abs_x = w_ext_x[ACC_W] ? -w_ext_x : w_ext_x;
  assign w_abs_y = w_ext_y[ACC_W] ? -w_ext_y : w_ext_y;

  always_comb begin
    w_comb = '0;
    case (r_mode)
      2'b00:   w_comb = {1'b0, w_abs_x} + {1'b0, w_abs_y};
      2'b01:   w_comb = {1'b0, w_abs_x};
      2'b10:   w_comb = {1'b0, w_abs_y};
      default: w_comb = (w_abs_x >= w_abs_y) ? {1'b0, w_abs_x} : {1'b0, w_abs_y};
    endcase
  end

  generate
    if (CMB_W > OUT_W) begin : g_sat_clip
      assign w_sat = (|w_comb[CMB_W-1:OUT_W]) ? {OUT_W{1'b1}} : w_comb[OUT_W-1:0];
    end else begin : g_sat_pass
      assign w_sat = OUT_W'(w_comb);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_S_IDLE;
      r_tap       <= '0;
      r_px        <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_mode      <= '0;
      r_acc_x     <= '0;
      r_acc_y     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_px       <= px_win;
            r_cx       <= coef_x;
            r_cy       <= coef_y;
            r_mode     <= mode;
            r_acc_x    <= '0;
            r_acc_y    <= '0;
            r_tap      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= c_S_MAC;
          end
        end
        c_S_MAC: begin
          r_acc_x <= r_acc_x + w_add_x;
          r_acc_y <= r_acc_y + w_add_y;
          if (r_tap == 4'd8) begin
            r_state <= c_S_FIN;
          end else begin
            r_tap <= r_tap + 4'd1;
          end
        end
        c_S_FIN: begin
          r_out_data  <= w_sat;
          r_out_valid <= 1'b1;
          r_state     <= c_S_OUT;
        end
        c_S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= c_S_IDLE;
          end
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != c_S_IDLE);

endmodule

`default_nettype wire
